// File: rtl/hs_sender.sv
// rtl/hs_sender.sv - four-phase req/ack handshake initiator
//
// Purpose: takes a WIDTH-bit word from the clk domain and delivers it to an
// asynchronous consumer over a four-phase req/ack handshake. req and data_out
// come straight from flops, and ack is synchronized before it is used.
//
// Optional feature macro: HS_SENDER_TIMEOUT_EN (per-phase timeout and sticky err).
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_data   in   word to send, captured on accept
//   in_valid  in   local word available
//   in_ready  out  high in IDLE (accept = in_valid & in_ready)
//   req       out  registered request to the far side
//   data_out  out  registered data, held from accept until back in IDLE and beyond
//   ack       in   asynchronous acknowledge from the far side
//   done      out  one-cycle pulse per completed handshake
//   err       out  sticky timeout flag (0 when the timeout is compiled out)

module hs_sender #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             req,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACKW = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic                   r_req;
    logic                   r_done;
    logic [WIDTH-1:0]       r_data;
    logic                   w_accept;
    logic                   w_set_err;
    logic                   w_done_set;
    logic                   w_timeout;
    logic                   w_err_q;

    assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
    assign in_ready = (r_state == ST_IDLE);
    assign req      = r_req;
    assign data_out = r_data;
    assign done     = r_done;

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_set_err  = 1'b0;
        w_done_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack_s already high here still counts as the acknowledge.
                if (w_ack_s) begin
                    w_next = ST_ACKW;
                end else if (w_timeout) begin
                    w_next    = ST_ACKW;
                    w_set_err = 1'b1;
                end
            end
            ST_ACKW: begin
                if (!w_ack_s) begin
                    w_next = ST_IDLE;
                    // err is cleared at accept, so a set err belongs to this transfer.
                    w_done_set = !w_err_q;
                end else if (w_timeout) begin
                    w_set_err = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ack_sync <= '0;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack};
            r_state    <= w_next;
            r_req      <= (w_next == ST_REQ);
            r_done     <= w_done_set;
            if (w_accept) begin
                r_data <= in_data;
            end
        end
    end

`ifdef HS_SENDER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_cnt;
    logic        r_err;

    assign w_timeout = (r_cnt == TO_LAST);
    assign w_err_q   = r_err;
    assign err       = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            // Counter saturates at TO_LAST so a long ACKW wait cannot wrap it.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state != ST_IDLE) && (r_cnt != TO_LAST)) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign w_err_q      = 1'b0;
    assign err          = 1'b0;
    assign w_unused_cfg = ^{TIMEOUT, w_set_err};
`endif

endmodule

// File: tb/tb_hs_sender.sv
// tb/tb_hs_sender.sv - directed self-checking bench for hs_sender

module tb_hs_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data  [2];
    logic [15:0] data_out [2];
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  req;
    logic [1:0]  ack;
    logic [1:0]  done;
    logic [1:0]  err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    hs_sender #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .req(req[0]), .data_out(data_out[0]),
        .ack(ack[0]), .done(done[0]), .err(err[0])
    );

    hs_sender #(.WIDTH(16), .SYNC_STAGES(4), .TIMEOUT(255)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .req(req[1]), .data_out(data_out[1]),
        .ack(ack[1]), .done(done[1]), .err(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps until req drops; reports cycles taken and whether data_out held.
    task automatic wait_req_low(input int d, input logic [15:0] word,
                                output int n, output logic stable);
        n      = 0;
        stable = 1'b1;
        while (req[d] === 1'b1 && n < 40) begin
            tick();
            n++;
            if (data_out[d] !== word) stable = 1'b0;
        end
    endtask

    task automatic wait_done(input int d, output int n);
        n = 0;
        while (done[d] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic single(input int d, input int s, input string nm);
        int   n;
        logic st;
        in_data[d]  = 16'hFF9C;
        in_valid[d] = 1'b1;
        tick();
        in_valid[d] = 1'b0;
        check({nm, "_req_rise"}, 32'(req[d]), 32'd1);
        check({nm, "_data"}, 32'(data_out[d]), 32'hFF9C);
        check({nm, "_busy"}, 32'(in_ready[d]), 32'd0);
        tick(); tick(); tick();
        ack[d] = 1'b1;
        wait_req_low(d, 16'hFF9C, n, st);
        check({nm, "_ack_rise_lat"}, 32'(n), 32'(s + 1));
        check({nm, "_data_held"}, 32'(st), 32'd1);
        tick(); tick(); tick();
        ack[d] = 1'b0;
        wait_done(d, n);
        check({nm, "_ack_fall_lat"}, 32'(n), 32'(s + 1));
        check({nm, "_ready_at_done"}, 32'(in_ready[d]), 32'd1);
        check({nm, "_data_after"}, 32'(data_out[d]), 32'hFF9C);
        tick();
        check({nm, "_done_pulse"}, 32'(done[d]), 32'd0);
    endtask

    initial begin
        int   n;
        logic st;
        logic saw_done;

        rst         = 1'b1;
        in_valid    = 2'b00;
        ack         = 2'b00;
        in_data[0]  = 16'h0000;
        in_data[1]  = 16'h0000;
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", 32'(in_ready[d]), 32'd1);
            check("rst_req", 32'(req[d]), 32'd0);
            check("rst_data", 32'(data_out[d]), 32'd0);
            check("rst_done", 32'(done[d]), 32'd0);
            check("rst_err", 32'(err[d]), 32'd0);
        end

        single(0, 2, "s2");
        single(1, 4, "s4");

        // back-to-back with in_valid held high
        in_data[0]  = 16'h0001;
        in_valid[0] = 1'b1;
        tick();
        check("b2b_first_data", 32'(data_out[0]), 32'h0001);
        in_data[0] = 16'h8000;
        ack[0]     = 1'b1;
        wait_req_low(0, 16'h0001, n, st);
        check("b2b_first_held", 32'(st), 32'd1);
        ack[0] = 1'b0;
        wait_done(0, n);
        check("b2b_first_done_lat", 32'(n), 32'd3);
        check("b2b_ready", 32'(in_ready[0]), 32'd1);
        tick();
        check("b2b_second_req", 32'(req[0]), 32'd1);
        check("b2b_second_data", 32'(data_out[0]), 32'h8000);
        check("b2b_done_low", 32'(done[0]), 32'd0);
        in_valid[0] = 1'b0;
        ack[0]      = 1'b1;
        wait_req_low(0, 16'h8000, n, st);
        check("b2b_second_held", 32'(st), 32'd1);
        ack[0] = 1'b0;
        wait_done(0, n);
        check("b2b_second_done_lat", 32'(n), 32'd3);
        tick();

        // early ack: ack already high at the accept
        ack[0] = 1'b1;
        tick(); tick(); tick();
        check("early_idle_ready", 32'(in_ready[0]), 32'd1);
        in_data[0]  = 16'h5A5A;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        check("early_req_rise", 32'(req[0]), 32'd1);
        tick();
        check("early_req_one_cycle", 32'(req[0]), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done[0] === 1'b1 || in_ready[0] === 1'b1) saw_done = 1'b1;
        end
        check("early_waits_ackw", 32'(saw_done), 32'd0);
        ack[0] = 1'b0;
        wait_done(0, n);
        check("early_done_lat", 32'(n), 32'd3);
        check("early_data", 32'(data_out[0]), 32'h5A5A);
        tick();

`ifdef HS_SENDER_TIMEOUT_EN
        in_data[0]  = 16'h0BAD;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        check("to_req_rise", 32'(req[0]), 32'd1);
        wait_req_low(0, 16'h0BAD, n, st);
        check("to_req_fall_lat", 32'(n), 32'd8);
        check("to_err_set", 32'(err[0]), 32'd1);
        saw_done = done[0];
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done[0] === 1'b1) saw_done = 1'b1;
        end
        check("to_no_done", 32'(saw_done), 32'd0);
        check("to_back_idle", 32'(in_ready[0]), 32'd1);
        check("to_err_sticky", 32'(err[0]), 32'd1);
        in_data[0]  = 16'h00AA;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        check("to_err_cleared", 32'(err[0]), 32'd0);
        ack[0] = 1'b1;
        wait_req_low(0, 16'h00AA, n, st);
        ack[0] = 1'b0;
        wait_done(0, n);
        check("to_recover_done_lat", 32'(n), 32'd3);
        tick();
`endif

        // asynchronous reset in the middle of REQ
        in_data[0]  = 16'h1234;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        check("mid_req", 32'(req[0]), 32'd1);
        check("mid_data", 32'(data_out[0]), 32'h1234);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", 32'(req[0]), 32'd0);
        check("arst_data", 32'(data_out[0]), 32'd0);
        check("arst_ready", 32'(in_ready[0]), 32'd1);
        check("arst_done", 32'(done[0]), 32'd0);
        check("arst_err", 32'(err[0]), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        check("post_rst_no_done", 32'(done[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
